// File: rtl/sim_run_controller.sv
// Run sequencer for the simulation top: DUT reset, settle delay, divided derived clock,
// cycle watchdog and finish request, all from one clock with registered outputs.
module sim_run_controller #(
    parameter int RESET_CYCLES  = 5,
    parameter int SETTLE_CYCLES = 10,
    parameter int DERIVED_DIV   = 1,
    parameter int TIMEOUT_W     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 dut_done,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic                 nRST_dut,
    output logic                 CLK_derivedClock,
    output logic                 nRST_derivedReset,
    output logic                 started,
    output logic                 running,
    output logic                 finish,
    output logic                 timed_out,
    output logic [TIMEOUT_W-1:0] cycle_count
);

    localparam int PHASE_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int DW        = (DERIVED_DIV > 1) ? $clog2(DERIVED_DIV) : 1;

    localparam logic [PW-1:0] RESET_LAST  = PW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(DERIVED_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [DW-1:0]        div_q, div_d;
    logic                 dclk_q, dclk_d;
    logic                 nrst_dut_q, nrst_dut_d;
    logic                 nrst_drv_q, nrst_drv_d;
    logic                 started_q, started_d;
    logic                 running_q, running_d;
    logic                 finish_q, finish_d;
    logic                 timed_out_q, timed_out_d;
    logic [TIMEOUT_W-1:0] count_q, count_d;

    // Sequencing: phase counter for RESET/SETTLE, RUN watchdog, DONE is sticky until RST.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        timed_out_d = timed_out_q;
        count_d     = count_q;
        unique case (state_q)
            S_IDLE: begin
                phase_d     = '0;
                timed_out_d = 1'b0;
                count_d     = '0;
                if (start) state_d = S_RESET;
            end
            S_RESET: begin
                if (phase_q == RESET_LAST) begin
                    state_d = S_SETTLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    phase_d = '0;
                    count_d = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_RUN: begin
                if (dut_done) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b0;
                end else if ((timeout_limit != '0) &&
                             (count_q == timeout_limit - TIMEOUT_W'(1))) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b1;
                end else if (count_q != '1) begin
                    count_d = count_q + TIMEOUT_W'(1);
                end
            end
            S_DONE: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Divider follows the next state so the derived clock lines up with the state it belongs to.
    always_comb begin
        div_d  = div_q;
        dclk_d = dclk_q;
        unique case (state_d)
            S_RESET, S_SETTLE, S_RUN: begin
                if (state_q == S_IDLE || div_q == DIV_LAST) begin
                    div_d = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
                if (div_d == DIV_LAST) dclk_d = ~dclk_q;
            end
            S_DONE: begin
            end
            default: begin
                div_d  = '0;
                dclk_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        nrst_dut_d = (state_d == S_SETTLE) || (state_d == S_RUN) || (state_d == S_DONE);
        nrst_drv_d = (state_d == S_RUN) || (state_d == S_DONE);
        started_d  = (state_d == S_RUN) && (state_q == S_SETTLE);
        running_d  = (state_d == S_RUN);
        finish_d   = (state_d == S_DONE);
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            div_q       <= '0;
            dclk_q      <= 1'b0;
            nrst_dut_q  <= 1'b0;
            nrst_drv_q  <= 1'b0;
            started_q   <= 1'b0;
            running_q   <= 1'b0;
            finish_q    <= 1'b0;
            timed_out_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            dclk_q      <= dclk_d;
            nrst_dut_q  <= nrst_dut_d;
            nrst_drv_q  <= nrst_drv_d;
            started_q   <= started_d;
            running_q   <= running_d;
            finish_q    <= finish_d;
            timed_out_q <= timed_out_d;
            count_q     <= count_d;
        end
    end

    assign nRST_dut          = nrst_dut_q;
    assign CLK_derivedClock  = dclk_q;
    assign nRST_derivedReset = nrst_drv_q;
    assign started           = started_q;
    assign running           = running_q;
    assign finish            = finish_q;
    assign timed_out         = timed_out_q;
    assign cycle_count       = count_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: two instances share stimulus, one with a
// divide-by-3 derived clock and one with the default divider.
module tb_sim_run_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        dut_done;
    logic [31:0] timeout_limit;

    logic        nrst_dut, dclk, nrst_drv, started, running, finish, timed_out;
    logic [31:0] cycle_count;
    logic        nrst_dut_1, dclk_1, nrst_drv_1, started_1, running_1, finish_1, timed_out_1;
    logic [31:0] cycle_count_1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sim_run_controller #(
        .RESET_CYCLES(5), .SETTLE_CYCLES(10), .DERIVED_DIV(3), .TIMEOUT_W(32)
    ) u_dut (
        .CLK(CLK), .RST(RST), .start(start), .dut_done(dut_done),
        .timeout_limit(timeout_limit),
        .nRST_dut(nrst_dut), .CLK_derivedClock(dclk), .nRST_derivedReset(nrst_drv),
        .started(started), .running(running), .finish(finish),
        .timed_out(timed_out), .cycle_count(cycle_count)
    );

    sim_run_controller #(
        .RESET_CYCLES(5), .SETTLE_CYCLES(10), .DERIVED_DIV(1), .TIMEOUT_W(32)
    ) u_dut_div1 (
        .CLK(CLK), .RST(RST), .start(start), .dut_done(dut_done),
        .timeout_limit(timeout_limit),
        .nRST_dut(nrst_dut_1), .CLK_derivedClock(dclk_1), .nRST_derivedReset(nrst_drv_1),
        .started(started_1), .running(running_1), .finish(finish_1),
        .timed_out(timed_out_1), .cycle_count(cycle_count_1)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are observed 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        start    = 1'b0;
        dut_done = 1'b0;
        step();
        step();
        RST = 1'b0;
    endtask

    // Starts a run at cycle 0 (start held high) and checks every cycle up to n.
    task automatic run_prefix(input string tag, input int n);
        logic [4:0] obs, exp;
        start = 1'b1;
        cyc   = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            obs = {nrst_dut, nrst_drv, started, running, finish};
            exp = {cyc >= 6, cyc >= 16, cyc == 16, cyc >= 16, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s ctrl cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
            end
            total++;
            if (cycle_count !== ((cyc >= 16) ? 32'(cyc - 16) : 32'd0)) begin
                bad++;
                $display("FAIL %s count cyc=%0d got=%0d", tag, cyc, cycle_count);
            end
            total++;
            if (dclk !== 1'((cyc / 3) % 2) || dclk_1 !== 1'(cyc % 2)) begin
                bad++;
                $display("FAIL %s dclk cyc=%0d got=%b/%b want=%b/%b", tag, cyc,
                         dclk, dclk_1, 1'((cyc / 3) % 2), 1'(cyc % 2));
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({nrst_dut, dclk, nrst_drv, started, running, finish, timed_out} !== 7'b0 ||
            cycle_count !== 32'd0 || dclk_1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=%b count=%0d", {nrst_dut, dclk, nrst_drv, started,
                     running, finish, timed_out}, cycle_count);
        end
        dut_done = 1'b1;
        repeat (3) step();
        dut_done = 1'b0;
        total++;
        if ({nrst_dut, dclk, nrst_drv, started, running, finish, timed_out} !== 7'b0 ||
            dclk_1 !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold got=%b", {nrst_dut, dclk, nrst_drv, started, running,
                     finish, timed_out});
        end
    endtask

    task automatic test_sequence();
        do_reset();
        timeout_limit = 32'd0;
        run_prefix("sequence", 22);
    endtask

    task automatic test_timeout();
        do_reset();
        timeout_limit = 32'd100;
        start = 1'b1;
        cyc   = 0;
        step_to(115);
        total++;
        if (running !== 1'b1 || finish !== 1'b0 || cycle_count !== 32'd99) begin
            bad++;
            $display("FAIL timeout_last_run running=%b finish=%b count=%0d want 1 0 99",
                     running, finish, cycle_count);
        end
        step();
        total++;
        if ({finish, timed_out, running, nrst_dut, nrst_drv, started} !== 6'b110110 ||
            cycle_count !== 32'd99) begin
            bad++;
            $display("FAIL timeout_fire flags=%b want=110110 count=%0d want 99",
                     {finish, timed_out, running, nrst_dut, nrst_drv, started}, cycle_count);
        end
        repeat (10) step();
        total++;
        if ({finish, timed_out, running, started} !== 4'b1100 || cycle_count !== 32'd99) begin
            bad++;
            $display("FAIL done_hold flags=%b want=1100 count=%0d want 99",
                     {finish, timed_out, running, started}, cycle_count);
        end
        total++;
        if (dclk !== 1'b0 || dclk_1 !== 1'b1) begin
            bad++;
            $display("FAIL dclk_freeze got=%b/%b want=0/1", dclk, dclk_1);
        end
        start = 1'b0;
    endtask

    task automatic test_done();
        do_reset();
        timeout_limit = 32'd100;
        start = 1'b1;
        cyc   = 0;
        step_to(10);
        dut_done = 1'b1;
        step();
        dut_done = 1'b0;
        total++;
        if (finish !== 1'b0 || nrst_dut !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL done_in_settle finish=%b nrst=%b running=%b want 0 1 0",
                     finish, nrst_dut, running);
        end
        step_to(40);
        dut_done = 1'b1;
        total++;
        if (finish !== 1'b0 || cycle_count !== 32'd24) begin
            bad++;
            $display("FAIL done_pre finish=%b count=%0d want 0 24", finish, cycle_count);
        end
        step();
        dut_done = 1'b0;
        total++;
        if ({finish, timed_out, running} !== 3'b100 || cycle_count !== 32'd24) begin
            bad++;
            $display("FAIL done_fire flags=%b want=100 count=%0d want 24",
                     {finish, timed_out, running}, cycle_count);
        end
        repeat (5) step();
        total++;
        if (finish !== 1'b1 || cycle_count !== 32'd24) begin
            bad++;
            $display("FAIL done_freeze finish=%b count=%0d want 1 24", finish, cycle_count);
        end
    endtask

    task automatic test_tie();
        do_reset();
        timeout_limit = 32'd10;
        start = 1'b1;
        cyc   = 0;
        step_to(25);
        total++;
        if (running !== 1'b1 || cycle_count !== 32'd9) begin
            bad++;
            $display("FAIL tie_pre running=%b count=%0d want 1 9", running, cycle_count);
        end
        dut_done = 1'b1;
        step();
        dut_done = 1'b0;
        total++;
        if ({finish, timed_out} !== 2'b10 || cycle_count !== 32'd9) begin
            bad++;
            $display("FAIL tie_fire finish/timed_out=%b want=10 count=%0d", {finish, timed_out},
                     cycle_count);
        end
        do_reset();
        start = 1'b1;
        cyc   = 0;
        step_to(25);
        total++;
        if (finish !== 1'b0) begin
            bad++;
            $display("FAIL short_timeout_pre finish=%b want 0", finish);
        end
        step();
        total++;
        if ({finish, timed_out} !== 2'b11 || cycle_count !== 32'd9) begin
            bad++;
            $display("FAIL short_timeout finish/timed_out=%b want=11 count=%0d want 9",
                     {finish, timed_out}, cycle_count);
        end
    endtask

    task automatic test_no_timeout();
        do_reset();
        timeout_limit = 32'd0;
        start = 1'b1;
        cyc   = 0;
        step_to(300);
        total++;
        if (running !== 1'b1 || finish !== 1'b0 || cycle_count !== 32'd284) begin
            bad++;
            $display("FAIL no_timeout running=%b finish=%b count=%0d want 1 0 284",
                     running, finish, cycle_count);
        end
        timeout_limit = 32'd290;
        step_to(305);
        total++;
        if (finish !== 1'b0 || cycle_count !== 32'd289) begin
            bad++;
            $display("FAIL limit_change_pre finish=%b count=%0d want 0 289", finish, cycle_count);
        end
        step();
        total++;
        if ({finish, timed_out} !== 2'b11 || cycle_count !== 32'd289) begin
            bad++;
            $display("FAIL limit_change finish/timed_out=%b want=11 count=%0d want 289",
                     {finish, timed_out}, cycle_count);
        end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        timeout_limit = 32'd100;
        start = 1'b1;
        cyc   = 0;
        step_to(20);
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL midrun_pre running=%b want 1", running);
        end
        RST = 1'b1;
        step();
        RST   = 1'b0;
        start = 1'b0;
        total++;
        if ({nrst_dut, dclk, nrst_drv, started, running, finish, timed_out} !== 7'b0 ||
            cycle_count !== 32'd0 || dclk_1 !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset got=%b count=%0d", {nrst_dut, dclk, nrst_drv, started,
                     running, finish, timed_out}, cycle_count);
        end
        repeat (3) step();
        total++;
        if ({nrst_dut, running, finish} !== 3'b0) begin
            bad++;
            $display("FAIL midrun_idle got=%b want=000", {nrst_dut, running, finish});
        end
        run_prefix("restart", 20);
        start = 1'b0;
    endtask

    initial begin
        RST           = 1'b1;
        start         = 1'b0;
        dut_done      = 1'b0;
        timeout_limit = 32'd0;
        test_reset();
        test_sequence();
        test_timeout();
        test_done();
        test_tie();
        test_no_timeout();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
